// File: rtl/fb_streamer_pkg.sv
// Purpose : shared types and constants for the framebuffer slice streamer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package fb_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } fb_state_t;

  // 8 mux segments x 48 channels x 9 bits of 30-bit driver words
  localparam int unsigned WORDS_PER_SLICE = 3456;
  localparam int unsigned SLICES_PER_TURN = 128;
  localparam int unsigned MUX_SEGMENTS    = 8;

  localparam int unsigned IDX_W   = 12;
  localparam int unsigned RAM_AW  = IDX_W + 1;  // {bank, word index}
  localparam int unsigned DATA_W  = 30;
  localparam int unsigned SLICE_W = 7;

endpackage

// File: rtl/fb_prefetch.sv
// Purpose : next-address mux for the framebuffer RAM plus the read-ahead output word register.
// Latency : RAM data lands in framebuffer_dat one cycle after it is returned (two after ram_addr).
// Backpressure: the word register only loads when the streamer asks; otherwise it holds.
// Ports   : state/restart/rd_bank/idx_nxt steer the address; load/clear steer the word register;
//           ram_addr/ram_rdata face the RAM; framebuffer_dat faces the driver stage.
module fb_prefetch
  import fb_streamer_pkg::*;
#(
  parameter int unsigned WORDS = 3456
) (
  input  logic              clk_lse,
  input  logic              nrst,
  input  fb_state_t         state,
  input  logic              restart,
  input  logic              rd_bank,
  input  logic [IDX_W-1:0]  idx_nxt,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] framebuffer_dat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0] word_sel;
  logic             bank_sel;

  // The RAM returns data one cycle late, so the address is always the word that
  // framebuffer_dat must be able to advance to next cycle: idx_nxt + 1.
  // A restart fetches word 0 of the bank that is about to become current.
  always_comb begin
    word_sel = '0;
    bank_sel = rd_bank;
    if (restart) begin
      bank_sel = ~rd_bank;
    end else if (state == ST_PRIME || state == ST_STREAM) begin
      word_sel = (idx_nxt == LAST_IDX) ? LAST_IDX : idx_nxt + IDX_W'(1);
    end
  end

  assign ram_addr = nrst ? {bank_sel, word_sel} : '0;

  always_ff @(posedge clk_lse or negedge nrst) begin
    if (!nrst) begin
      framebuffer_dat <= '0;
    end else if (clear) begin
      framebuffer_dat <= '0;
    end else if (load) begin
      framebuffer_dat <= ram_rdata;
    end
  end

endmodule

// File: rtl/fb_streamer.sv
// Purpose : streams one slice of framebuffer words per position_sync from the read bank to the drivers.
// Latency : position_sync -> word 0 on framebuffer_dat after 2 cycles; then one word per accepted cycle.
// Backpressure: driver_ready=0 holds the current word; protocol violations set sticky stream_error.
// Ports   : position_sync/driver_ready/column_ready from the driver side; ram_addr/ram_rdata to the
//           framebuffer RAM; framebuffer_dat/rd_bank/slice_idx/stream_error are status and data out.
module fb_streamer #(
  parameter int unsigned WORDS_PER_SLICE = fb_streamer_pkg::WORDS_PER_SLICE,
  parameter int unsigned SLICES_PER_TURN = fb_streamer_pkg::SLICES_PER_TURN
) (
  input  logic        clk_lse,
  input  logic        nrst,
  input  logic        position_sync,
  input  logic        driver_ready,
  input  logic        column_ready,
  output logic [12:0] ram_addr,
  input  logic [29:0] ram_rdata,
  output logic [29:0] framebuffer_dat,
  output logic        rd_bank,
  output logic [6:0]  slice_idx,
  output logic        stream_error
);
  import fb_streamer_pkg::*;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(WORDS_PER_SLICE - 1);
  localparam logic [IDX_W-1:0]   SEG_LAST   = IDX_W'(WORDS_PER_SLICE / MUX_SEGMENTS - 1);
  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICES_PER_TURN - 1);

  fb_state_t        state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] seg_word;   // position inside the current mux segment
  logic [2:0]       seg_cnt;
  logic             unused_seg_cnt;
  logic             consume;
  logic             last_word;
  logic             load;
  logic             clear;

  // position_sync outranks a same-cycle driver_ready: that consumption is dropped.
  assign last_word = (idx == LAST_IDX);
  assign consume   = (state == ST_STREAM) && driver_ready && !position_sync;
  assign idx_nxt   = position_sync          ? '0 :
                     (consume && !last_word) ? idx + IDX_W'(1) : idx;
  assign load      = !position_sync && ((state == ST_PRIME) || (consume && !last_word));
  assign clear     = consume && last_word;

  assign unused_seg_cnt = ^seg_cnt;

  fb_prefetch #(
    .WORDS (WORDS_PER_SLICE)
  ) u_prefetch (
    .clk_lse         (clk_lse),
    .nrst            (nrst),
    .state           (state),
    .restart         (position_sync),
    .rd_bank         (rd_bank),
    .idx_nxt         (idx_nxt),
    .load            (load),
    .clear           (clear),
    .ram_rdata       (ram_rdata),
    .ram_addr        (ram_addr),
    .framebuffer_dat (framebuffer_dat)
  );

  always_ff @(posedge clk_lse or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      seg_word     <= '0;
      seg_cnt      <= '0;
      rd_bank      <= 1'b0;
      slice_idx    <= SLICE_LAST;
      stream_error <= 1'b0;
    end else begin
      idx <= idx_nxt;
      if (position_sync) begin
        state     <= ST_PRIME;
        rd_bank   <= ~rd_bank;
        slice_idx <= (slice_idx == SLICE_LAST) ? '0 : slice_idx + SLICE_W'(1);
        seg_cnt   <= '0;
        seg_word  <= '0;
        // a slice still in flight is truncated
        if (state == ST_PRIME || state == ST_STREAM) begin
          stream_error <= 1'b1;
        end
      end else begin
        if (column_ready) begin
          seg_cnt <= seg_cnt + 3'd1;
        end
        if (consume) begin
          seg_word <= (seg_word == SEG_LAST) ? '0 : seg_word + IDX_W'(1);
        end
        case (state)
          ST_PRIME: begin
            state <= ST_STREAM;
            if (driver_ready) stream_error <= 1'b1;
          end
          ST_STREAM: begin
            if (consume && last_word) state <= ST_DONE;
            if (column_ready && seg_word != '0) stream_error <= 1'b1;
          end
          ST_DONE: begin
            if (driver_ready) stream_error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_streamer.sv
// Purpose : directed self-checking bench for fb_streamer (full-size instance plus a short-slice instance).
// Latency : n/a.
// Backpressure: n/a.
module tb_fb_streamer;

  logic        clk_lse;
  logic        nrst;
  logic        sync, ready, column;
  logic [12:0] addr;
  logic [29:0] rdata, fb;
  logic        bank, err;
  logic [6:0]  sidx;

  logic        sync_s, ready_s, column_s;
  logic [12:0] addr_s;
  logic [29:0] rdata_s, fb_s;
  logic        bank_s, err_s;
  logic [6:0]  sidx_s;

  int total;
  int bad;

  fb_streamer dut (
    .clk_lse(clk_lse), .nrst(nrst), .position_sync(sync), .driver_ready(ready),
    .column_ready(column), .ram_addr(addr), .ram_rdata(rdata), .framebuffer_dat(fb),
    .rd_bank(bank), .slice_idx(sidx), .stream_error(err)
  );

  fb_streamer #(.WORDS_PER_SLICE(16), .SLICES_PER_TURN(128)) dut_small (
    .clk_lse(clk_lse), .nrst(nrst), .position_sync(sync_s), .driver_ready(ready_s),
    .column_ready(column_s), .ram_addr(addr_s), .ram_rdata(rdata_s), .framebuffer_dat(fb_s),
    .rd_bank(bank_s), .slice_idx(sidx_s), .stream_error(err_s)
  );

  // RAM models: one-cycle read latency, data equals address
  always_ff @(posedge clk_lse) begin
    rdata   <= {17'd0, addr};
    rdata_s <= {17'd0, addr_s};
  end

  initial clk_lse = 1'b0;
  always #5 clk_lse = ~clk_lse;

  task automatic tick();
    @(posedge clk_lse);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (fb !== 30'd0) begin bad++; $display("FAIL reset_fb: got %h want %h", fb, 30'd0); end
    total++; if (addr !== 13'd0) begin bad++; $display("FAIL reset_addr: got %h want %h", addr, 13'd0); end
    total++; if (bank !== 1'b0) begin bad++; $display("FAIL reset_bank: got %b want 0", bank); end
    total++; if (sidx !== 7'd127) begin bad++; $display("FAIL reset_slice: got %0d want 127", sidx); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_full_slice();
    int gaps;
    gaps = 0;
    tick; nrst = 1'b1; tick;
    sync = 1'b1; #1;
    total++; if (addr !== 13'h1000) begin bad++; $display("FAIL sync_addr: got %h want %h", addr, 13'h1000); end
    tick; sync = 1'b0; #1;
    total++; if (bank !== 1'b1) begin bad++; $display("FAIL first_bank: got %b want 1", bank); end
    total++; if (sidx !== 7'd0) begin bad++; $display("FAIL first_slice: got %0d want 0", sidx); end
    total++; if (addr !== 13'h1001) begin bad++; $display("FAIL prime_addr: got %h want %h", addr, 13'h1001); end
    tick;
    ready = 1'b1;
    for (int n = 0; n < 3456; n++) begin
      if (fb !== 30'h1000 + 30'(n)) begin
        if (gaps == 0) $display("first stream deviation at word %0d: got %h", n, fb);
        gaps++;
      end
      tick;
    end
    ready = 1'b0;
    total++; if (gaps !== 0) begin bad++; $display("FAIL full_sequence: got %0d bad words want 0", gaps); end
    total++; if (fb !== 30'd0) begin bad++; $display("FAIL done_fb: got %h want 0", fb); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err: got %b want 0", err); end
  endtask

  task automatic test_hold();
    sync = 1'b1; tick; sync = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL done_restart_err: got %b want 0", err); end
    total++; if (bank !== 1'b0) begin bad++; $display("FAIL second_bank: got %b want 0", bank); end
    tick;
    ready = 1'b1; repeat (10) tick;
    total++; if (fb !== 30'd10) begin bad++; $display("FAIL hold_start: got %h want %h", fb, 30'd10); end
    tick;                       // ready=1
    ready = 1'b0; tick;         // ready=0
    total++; if (fb !== 30'd11) begin bad++; $display("FAIL hold_word_a: got %h want %h", fb, 30'd11); end
    total++; if (addr !== 13'd12) begin bad++; $display("FAIL hold_addr: got %h want %h", addr, 13'd12); end
    tick;                       // ready=0
    total++; if (fb !== 30'd11) begin bad++; $display("FAIL hold_word_b: got %h want %h", fb, 30'd11); end
    ready = 1'b1; tick;         // ready=1
    ready = 1'b0;
    total++; if (fb !== 30'd12) begin bad++; $display("FAIL hold_advance: got %h want %h", fb, 30'd12); end
  endtask

  task automatic test_truncate();
    ready = 1'b1; repeat (88) tick; ready = 1'b0;
    total++; if (fb !== 30'd100) begin bad++; $display("FAIL trunc_word100: got %h want %h", fb, 30'd100); end
    sync = 1'b1; tick; sync = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL trunc_err: got %b want 1", err); end
    total++; if (bank !== 1'b1) begin bad++; $display("FAIL trunc_bank: got %b want 1", bank); end
    total++; if (sidx !== 7'd2) begin bad++; $display("FAIL trunc_slice: got %0d want 2", sidx); end
    tick;
    total++; if (fb !== 30'h1000) begin bad++; $display("FAIL trunc_word0: got %h want %h", fb, 30'h1000); end
  endtask

  task automatic test_wrap();
    int wrong;
    logic [6:0] at127, at128;
    logic eb;
    wrong = 0; at127 = '0; at128 = 7'h7f;
    for (int k = 0; k < 130; k++) begin
      eb = (k % 2 == 0);
      sync_s = 1'b1; tick; sync_s = 1'b0;
      if (sidx_s !== 7'(k % 128) || bank_s !== eb) wrong++;
      if (k == 127) at127 = sidx_s;
      if (k == 128) at128 = sidx_s;
      tick;
      if (fb_s !== (30'(eb) << 12)) wrong++;
      ready_s = 1'b1; repeat (16) tick; ready_s = 1'b0;
    end
    total++; if (wrong !== 0) begin bad++; $display("FAIL wrap_sequence: got %0d wrong want 0", wrong); end
    total++; if (at127 !== 7'd127) begin bad++; $display("FAIL wrap_127: got %0d want 127", at127); end
    total++; if (at128 !== 7'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", at128); end
    total++; if (err_s !== 1'b0) begin bad++; $display("FAIL wrap_err: got %b want 0", err_s); end
  endtask

  task automatic test_done_pulse();
    ready_s = 1'b1; tick; ready_s = 1'b0;
    total++; if (err_s !== 1'b1) begin bad++; $display("FAIL done_pulse_err: got %b want 1", err_s); end
    total++; if (fb_s !== 30'd0) begin bad++; $display("FAIL done_pulse_fb: got %h want 0", fb_s); end
  endtask

  task automatic test_reset_midstream();
    ready = 1'b1; repeat (2000) tick; ready = 1'b0;
    total++; if (fb !== 30'h1000 + 30'd2000) begin bad++; $display("FAIL mid_word2000: got %h want %h", fb, 30'h1000 + 30'd2000); end
    #2; nrst = 1'b0; #1;
    total++; if (fb !== 30'd0) begin bad++; $display("FAIL async_fb: got %h want 0", fb); end
    total++; if (addr !== 13'd0) begin bad++; $display("FAIL async_addr: got %h want 0", addr); end
    total++; if (sidx !== 7'd127) begin bad++; $display("FAIL async_slice: got %0d want 127", sidx); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL async_err: got %b want 0", err); end
    tick; nrst = 1'b1; tick;
    sync = 1'b1; tick; sync = 1'b0;
    total++; if (sidx !== 7'd0) begin bad++; $display("FAIL rst_slice: got %0d want 0", sidx); end
    total++; if (bank !== 1'b1) begin bad++; $display("FAIL rst_bank: got %b want 1", bank); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    tick;
    total++; if (fb !== 30'h1000) begin bad++; $display("FAIL rst_word0: got %h want %h", fb, 30'h1000); end
  endtask

  task automatic test_column();
    column = 1'b1; tick; column = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL col_at0: got %b want 0", err); end
    ready = 1'b1; repeat (432) tick; ready = 1'b0;
    total++; if (fb !== 30'h1000 + 30'd432) begin bad++; $display("FAIL col_word432: got %h want %h", fb, 30'h1000 + 30'd432); end
    column = 1'b1; tick; column = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL col_at432: got %b want 0", err); end
    ready = 1'b1; repeat (5) tick; ready = 1'b0;
    column = 1'b1; tick; column = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL col_misaligned: got %b want 1", err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    nrst = 1'b0;
    sync = 1'b0; ready = 1'b0; column = 1'b0;
    sync_s = 1'b0; ready_s = 1'b0; column_s = 1'b0;
    test_reset();
    test_full_slice();
    test_hold();
    test_truncate();
    test_wrap();
    test_done_pulse();
    test_reset_midstream();
    test_column();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_streamer.md
FB_STREAMER -- requirements
Module: fb_streamer

Interface
REQ-001 Parameter WORDS_PER_SLICE, default 3456: 30-bit words per slice (8 mux × 48 channels × 9 bits).
REQ-002 Parameter SLICES_PER_TURN, default 128: slices per revolution.
REQ-003 Port clk_lse  input  1: sole clock; all logic on its rising edge.
REQ-004 Port nrst  input  1: reset, asynchronous and active-low.
REQ-005 Port position_sync  input  1: single-cycle pulse at the start of a new slice.
REQ-006 Port driver_ready  input  1: the driver stage consumes the current word this cycle.
REQ-007 Port column_ready  input  1: the driver stage has finished a mux segment.
REQ-008 Port ram_addr  output  13: {bank, word index[11:0]} to the framebuffer RAM read port.
REQ-009 Port ram_rdata  input  30: RAM read data, valid 1 cycle after ram_addr.
REQ-010 Port framebuffer_dat  output  30: current word, one bit per driver.
REQ-011 Port rd_bank  output  1: bank being read; the writer fills the other bank.
REQ-012 Port slice_idx  output  7: index of the slice being streamed.
REQ-013 Port stream_error  output  1: sticky underrun or truncation flag.

Function
REQ-014 States: IDLE, PRIME, STREAM, DONE.
REQ-015 IDLE: framebuffer_dat=0; driver_ready ignored; position_sync -> PRIME.
REQ-016 On every accepted position_sync:
  - word index cleared to 0;
  - rd_bank toggled;
  - slice_idx incremented, wrapping SLICES_PER_TURN-1 -> 0 (first sync after reset gives slice_idx=0 and rd_bank=1);
  - segment counter cleared;
  - ram_addr={new bank, 0} presented in the same cycle.
REQ-017 PRIME lasts exactly 1 cycle: ram_rdata of word 0 is captured, then the state moves to STREAM.
REQ-018 STREAM: framebuffer_dat always holds word N of the current bank, and ram_addr presents N+1 in advance.
REQ-019 In STREAM, a cycle with driver_ready=1 makes framebuffer_dat show word N+1 on the next cycle (zero-bubble; back-to-back consumption sustained indefinitely).
REQ-020 In STREAM, driver_ready=0 holds framebuffer_dat and the index unchanged.
REQ-021 Consuming word WORDS_PER_SLICE-1 -> DONE. framebuffer_dat=0 in DONE.
REQ-022 driver_ready=1 while in DONE or PRIME: set stream_error; the output stays 0 (DONE) or unchanged (PRIME).
REQ-023 position_sync while in STREAM or PRIME: set stream_error and restart per REQ-016 (slice truncated).
REQ-024 position_sync while in DONE: normal restart per REQ-016.
REQ-025 position_sync and driver_ready in the same cycle: position_sync wins; the consumption is discarded without error.
REQ-026 column_ready increments a 3-bit segment counter.
REQ-027 column_ready in STREAM while the index is not at a multiple of WORDS_PER_SLICE/8: set stream_error (misalignment).
REQ-028 Word index arithmetic is 12-bit unsigned and never exceeds WORDS_PER_SLICE-1.
REQ-029 ram_addr is combinational from the registered index and the next-index decision; all other outputs are registered.

Reset
REQ-030 Asynchronous assertion of nrst forces, within the same cycle:
  - state=IDLE, framebuffer_dat=0, ram_addr=0;
  - rd_bank=0, slice_idx=SLICES_PER_TURN-1;
  - segment counter=0, stream_error=0.
REQ-031 Reset asserted mid-STREAM abandons the slice with no error; the next position_sync after release behaves as the first.
REQ-032 stream_error is cleared only by nrst.

Structure
REQ-033 The shared driver package holds:
  - the state enum;
  - WORDS_PER_SLICE, SLICES_PER_TURN and MUX_SEGMENTS=8 constants;
  - the ram address width.
REQ-034 One sub-module, fb_prefetch, holds the 1-deep read-ahead register and the next-address mux; the FSM and counters stay in fb_streamer.

Verification
REQ-035 Reset, one position_sync, then driver_ready held high for 3456 cycles, with the RAM model returning data=address:
  - framebuffer_dat steps 0,1,2,…,3455 with no repeats or gaps;
  - DONE is entered;
  - stream_error=0.
REQ-036 Mid-slice, driver_ready toggles 1,0,0,1:
  - the word is held during the 0 cycles;
  - the index advances by exactly 2.
REQ-037 position_sync at word 100 of a slice:
  - stream_error=1;
  - rd_bank toggles;
  - framebuffer_dat shows word 0 of the new bank 2 cycles later.
REQ-038 130 complete slices:
  - slice_idx wraps 127->0;
  - rd_bank alternates every slice;
  - stream_error=0.
REQ-039 driver_ready pulsed in DONE: stream_error=1 and framebuffer_dat=0.
REQ-040 nrst asserted at word 2000, then released, then position_sync:
  - slice_idx=0, rd_bank=1, stream_error=0;
  - framebuffer_dat=word 0.
